// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// and a DMA/loader master. Grants are combinational from registered
// arbitration state. A starvation counter forces DMA through after
// STARVE_LIMIT contested CPU wins. Locked DMA bursts are capped at MAX_BURST
// grants.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} mode_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);

  mode_t             mode_q, mode_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic [7:0]        burst_inc;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              cpu_gnt;
  logic              dma_gnt_w;

  // Grant decision: LOCKED belongs to DMA; FREE favours the CPU until starved.
  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt_w = 1'b0;
    if (mode_q == LOCKED) begin
      dma_gnt_w = dma_req;
    end else if (cpu_req && dma_req) begin
      if (starve_cnt_q == STARVE_MAX) begin
        dma_gnt_w = 1'b1;
      end else begin
        cpu_gnt = 1'b1;
      end
    end else begin
      cpu_gnt   = cpu_req;
      dma_gnt_w = dma_req;
    end
  end

  // Port mux. With no grant the CPU address/data still drive the bus, but
  // both enables stay low.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (dma_gnt_w) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_re    = ~dma_we;
      mem_we    = dma_we;
    end else if (cpu_gnt) begin
      mem_re = ~cpu_we;
      mem_we = cpu_we;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign dma_gnt    = dma_gnt_w;
  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign burst_inc  = burst_cnt_q + 8'd1;

  // Next-state for mode, the starvation/burst counters and DMA read capture.
  always_comb begin
    mode_d       = mode_q;
    starve_cnt_d = starve_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    dma_rvalid_d = dma_gnt_w & ~dma_we;
    dma_rdata_d  = dma_rdata_q;

    if (dma_rvalid_d) begin
      dma_rdata_d = mem_rdata;
    end

    // Starvation only accrues on contested cycles that the CPU wins.
    if (dma_gnt_w || !dma_req) begin
      starve_cnt_d = 4'd0;
    end else if (cpu_gnt && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    case (mode_q)
      FREE: begin
        if (dma_gnt_w && dma_lock) begin
          // A single-grant burst limit releases as soon as the lock is entered.
          if (BURST_MAX == 8'd1) begin
            burst_cnt_d = 8'd0;
          end else begin
            mode_d      = LOCKED;
            burst_cnt_d = 8'd1;
          end
        end
      end
      LOCKED: begin
        if (!dma_req || !dma_lock || burst_inc == BURST_MAX) begin
          mode_d      = FREE;
          burst_cnt_d = 8'd0;
        end else begin
          burst_cnt_d = burst_inc;
        end
      end
      default: begin
        mode_d      = FREE;
        burst_cnt_d = 8'd0;
      end
    endcase
  end

  // State registers; reset drops any pending DMA read result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q       <= FREE;
      starve_cnt_q <= 4'd0;
      burst_cnt_q  <= 8'd0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      mode_q       <= mode_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle grant/mux checks plus a
// queue of expected DMA read results popped when dma_rvalid arrives.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_re, mem_we;

  logic [31:0] mem [0:255];
  logic [31:0] rd_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .MAX_BURST(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Behavioural data memory: combinational read, write on clock edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after each clock edge: rvalid must match scoreboard occupancy.
  task automatic sb_check(input string tag);
    check({tag, "_rvalid"}, {31'd0, dma_rvalid}, {31'd0, rd_q.size() != 0});
    if (dma_rvalid && rd_q.size() != 0) check({tag, "_rdata"}, dma_rdata, rd_q.pop_front());
  endtask

  // One bus cycle: drive both masters, check grant and mux, advance the clock.
  task automatic step(input string tag,
                      input logic c_r, input logic c_w, input logic [31:0] c_a, input logic [31:0] c_d,
                      input logic d_r, input logic d_w, input logic d_l,
                      input logic [31:0] d_a, input logic [31:0] d_d,
                      input logic e_dgnt, input logic e_stall);
    logic [31:0] e_addr, e_wdata;
    logic        e_re, e_we;
    @(negedge clk);
    cpu_req = c_r; cpu_we = c_w; cpu_addr = c_a; cpu_wdata = c_d;
    dma_req = d_r; dma_we = d_w; dma_lock = d_l; dma_addr = d_a; dma_wdata = d_d;
    #2;
    if (e_dgnt) begin
      e_addr = d_a; e_wdata = d_d; e_we = d_w; e_re = ~d_w;
    end else begin
      e_addr = c_a; e_wdata = c_d;
      e_we = c_r & ~e_stall & c_w;
      e_re = c_r & ~e_stall & ~c_w;
    end
    $display("cycle %s: cpu_req=%0b dma_req=%0b lock=%0b -> dma_gnt=%0b cpu_stall=%0b addr=0x%08h",
             tag, c_r, d_r, d_l, dma_gnt, cpu_stall, mem_addr);
    check({tag, "_dgnt"},  {31'd0, dma_gnt},   {31'd0, e_dgnt});
    check({tag, "_stall"}, {31'd0, cpu_stall}, {31'd0, e_stall});
    check({tag, "_addr"},  mem_addr,  e_addr);
    check({tag, "_wdata"}, mem_wdata, e_wdata);
    check({tag, "_re"},    {31'd0, mem_re}, {31'd0, e_re});
    check({tag, "_we"},    {31'd0, mem_we}, {31'd0, e_we});
    check({tag, "_crd"},   cpu_rdata, mem[e_addr[9:2]]);
    if (e_dgnt && !d_w) rd_q.push_back(mem[d_a[9:2]]);
    @(posedge clk);
    #1;
    sb_check(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    mem[4]  <= 32'hDEAD_BEEF;
    mem[64] <= 32'hCAFE_0001;
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = 0; dma_wdata = 0;

    // Reset state
    @(negedge clk);
    check("rst_rvalid", {31'd0, dma_rvalid}, 32'd0);
    check("rst_rdata",  dma_rdata, 32'd0);
    check("rst_dgnt",   {31'd0, dma_gnt}, 32'd0);
    check("rst_stall",  {31'd0, cpu_stall}, 32'd0);
    check("rst_re",     {31'd0, mem_re}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // CPU alone: read, then write and read back
    step("cpu_rd", 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    check("cpu_rd_beef", cpu_rdata, 32'hDEAD_BEEF);
    step("cpu_wr", 1, 1, 32'h20, 32'h1234_5678, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    check("cpu_wr_commit", mem[8], 32'h1234_5678);

    // DMA alone: read (rvalid in N+1 only), then write
    step("dma_rd", 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h100, 32'h0, 1, 0);
    check("dma_rd_val", dma_rdata, 32'hCAFE_0001);
    idle("idle0");
    step("dma_wr", 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h104, 32'h5555_AAAA, 1, 0);
    check("dma_wr_commit", mem[65], 32'h5555_AAAA);

    // Contested, no lock: CPU x4 then DMA, repeating
    for (int i = 0; i < 10; i++)
      step("contend", 1, 0, 32'h40 + 32'(4 * i), 32'h0, 1, 0, 0, 32'h180 + 32'(4 * i), 32'h0,
           (i % 5) == 4, (i % 5) == 4);
    idle("idle1");

    // Locked burst with CPU waiting: 4 CPU wins, 8 DMA grants, then CPU
    for (int i = 0; i < 13; i++)
      step("burst", 1, 0, 32'h80, 32'h0, 1, 0, 1, 32'h200 + 32'(4 * i), 32'h0,
           (i >= 4 && i <= 11), (i >= 4 && i <= 11));
    idle("idle2");

    // Lock dropped on third grant: CPU wins next, starvation count restarts
    step("drop0", 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h300, 32'h0, 1, 0);
    step("drop1", 1, 0, 32'h90, 32'h0, 1, 0, 1, 32'h304, 32'h0, 1, 1);
    step("drop2", 1, 0, 32'h90, 32'h0, 1, 0, 0, 32'h308, 32'h0, 1, 1);
    for (int i = 0; i < 5; i++)
      step("after_drop", 1, 0, 32'h94, 32'h0, 1, 0, 0, 32'h30C, 32'h0, i == 4, i == 4);
    idle("idle3");

    // LOCKED with dma_req low: no grant that cycle, then FREE
    step("lk_gnt", 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h310, 32'h0, 1, 0);
    step("lk_noreq", 1, 0, 32'hA0, 32'h0, 0, 0, 1, 32'h0, 32'h0, 0, 1);
    step("lk_free", 1, 0, 32'hA0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    idle("idle4");

    // Reset mid-burst at grant 4 with a read pending
    step("rb_g1", 0, 0, 32'h0, 32'h0, 1, 0, 1, 32'h320, 32'h0, 1, 0);
    step("rb_g2", 1, 0, 32'h30, 32'h0, 1, 0, 1, 32'h324, 32'h0, 1, 1);
    step("rb_g3", 1, 0, 32'h30, 32'h0, 1, 0, 1, 32'h328, 32'h0, 1, 1);
    @(negedge clk);
    dma_addr = 32'h32C;
    #2;
    check("rb_g4_dgnt",  {31'd0, dma_gnt}, 32'd1);
    check("rb_g4_stall", {31'd0, cpu_stall}, 32'd1);
    reset = 1'b0;
    #1;
    check("rb_rst_dgnt",  {31'd0, dma_gnt}, 32'd0);
    check("rb_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rb_rst_addr",  mem_addr, 32'h30);
    @(posedge clk);
    #1;
    check("rb_rvalid", {31'd0, dma_rvalid}, 32'd0);
    check("rb_rdata",  dma_rdata, 32'd0);
    @(negedge clk);
    cpu_req = 0; dma_req = 0; dma_lock = 0;
    reset = 1'b1;
    step("rb_cpu", 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    check("rb_cpu_rd", cpu_rdata, 32'hDEAD_BEEF);
    idle("idle5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
